// File: rtl/tt_um_sign_addsub_seq_if.sv
// Pin bundle for the sequential signed add/sub unit: operand byte, control byte,
// result byte and status byte, plus the design enable.
interface tt_um_sign_addsub_seq_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/tt_um_sign_addsub_seq.sv
// Sequential 8-bit add/subtract with valid/ready handshakes, signed overflow and
// carry/borrow flags; the last result can be chained in as the next A operand.
module tt_um_sign_addsub_seq (
   input  logic                          clk,
   input  logic                          rst_n,
   tt_um_sign_addsub_seq_if.slave        bus
);

   typedef enum logic [1:0] {IDLE, WAIT_B, CALC, DONE} state_t;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [7:0] r_res;
   logic       r_op;
   logic       r_ovf;
   logic       r_cb;

   logic       w_inValid;
   logic       w_opIn;
   logic       w_accIn;
   logic       w_ackIn;
   logic       w_inReady;
   logic       w_outValid;
   logic       w_xfer;
   logic [8:0] w_sum;
   logic       w_ovf;
   logic       w_unused;

   assign w_inValid = bus.uio_in[0];
   assign w_opIn    = bus.uio_in[1];
   assign w_accIn   = bus.uio_in[2];
   assign w_ackIn   = bus.uio_in[3];
   assign w_unused  = ^bus.uio_in[7:4];

   assign w_xfer = bus.ena & w_inValid & w_inReady;

   // Bit 8 of the 9-bit difference is exactly the unsigned borrow (A < B).
   assign w_sum = r_op ? ({1'b0, r_a} - {1'b0, r_b}) : ({1'b0, r_a} + {1'b0, r_b});
   assign w_ovf = r_op ? ((r_a[7] != r_b[7]) && (w_sum[7] != r_a[7]))
                       : ((r_a[7] == r_b[7]) && (w_sum[7] != r_a[7]));

   always_comb begin
      w_next     = r_state;
      w_inReady  = 1'b0;
      w_outValid = 1'b0;
      case (r_state)
         IDLE: begin
            w_inReady = 1'b1;
            if (w_inValid)
               w_next = w_accIn ? CALC : WAIT_B;
         end
         WAIT_B: begin
            w_inReady = 1'b1;
            if (w_inValid)
               w_next = CALC;
         end
         CALC: w_next = DONE;
         DONE: begin
            w_outValid = 1'b1;
            if (w_ackIn)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // With ena low every register, including the FSM, holds its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else if (bus.ena)
         r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= 8'h00;
         r_b   <= 8'h00;
         r_op  <= 1'b0;
         r_res <= 8'h00;
         r_ovf <= 1'b0;
         r_cb  <= 1'b0;
      end else if (bus.ena) begin
         case (r_state)
            IDLE: begin
               if (w_xfer && w_accIn) begin
                  r_a  <= r_res;
                  r_b  <= bus.ui_in;
                  r_op <= w_opIn;
               end else if (w_xfer) begin
                  r_a <= bus.ui_in;
               end
            end
            WAIT_B: begin
               if (w_xfer) begin
                  r_b  <= bus.ui_in;
                  r_op <= w_opIn;
               end
            end
            CALC: begin
               r_res <= w_sum[7:0];
               r_ovf <= w_ovf;
               r_cb  <= w_sum[8];
            end
            default: ;
         endcase
      end
   end

   assign bus.uo_out  = r_res;
   assign bus.uio_out = {r_cb, r_ovf, w_outValid, w_inReady, 4'b0000};
   assign bus.uio_oe  = 8'hF0;

endmodule
